// File: rtl/game_flow_ctrl.sv
// Game flow controller: play state, lives, levels, pill count,
// ghost collisions and frightened-mode timing.
module game_flow_ctrl #(
    parameter int N_GHOSTS      = 2,
    parameter int X_W           = 6,
    parameter int Y_W           = 5,
    parameter int START_LIVES   = 3,
    parameter int TOTAL_PILLS   = 300,
    parameter int PILL_W        = 9,
    parameter int RESUME_CYCLES = 250000000,
    parameter int FRIGHT_CYCLES = 350000000
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    pause,
    input  logic [X_W-1:0]          pac_x,
    input  logic [Y_W-1:0]          pac_y,
    input  logic [N_GHOSTS*X_W-1:0] ghost_x,
    input  logic [N_GHOSTS*Y_W-1:0] ghost_y,
    input  logic                    pill_eaten,
    input  logic                    power_eaten,
    output logic [2:0]              state,
    output logic [2:0]              lives,
    output logic [3:0]              level,
    output logic [PILL_W-1:0]       pills_left,
    output logic                    sprite_reset,
    output logic                    map_wr_reset,
    output logic                    disp_reset,
    output logic                    ghost_enable,
    output logic                    frightened,
    output logic [N_GHOSTS-1:0]     ghost_eaten,
    output logic                    death,
    output logic                    level_clear
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_GAME   = 3'd1,
        S_PAUSE  = 3'd2,
        S_RESUME = 3'd3,
        S_CLEAR  = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    localparam int DW = (RESUME_CYCLES > 1) ? $clog2(RESUME_CYCLES) : 1;
    localparam int FW = $clog2(FRIGHT_CYCLES + 1);
    localparam logic [DW-1:0]     DWELL_LAST  = DW'(RESUME_CYCLES - 1);
    localparam logic [FW-1:0]     FRIGHT_LOAD = FW'(FRIGHT_CYCLES);
    localparam logic [PILL_W-1:0] PILL_LOAD   = PILL_W'(TOTAL_PILLS);
    localparam logic [2:0]        LIVES_LOAD  = 3'(START_LIVES);

    state_t              state_q, state_d;
    logic [2:0]          lives_q, lives_d;
    logic [3:0]          level_q, level_d;
    logic [PILL_W-1:0]   pills_q, pills_d;
    logic                fright_q, fright_d;
    logic [FW-1:0]       fcnt_q, fcnt_d;
    logic [DW-1:0]       dcnt_q, dcnt_d;
    logic [N_GHOSTS-1:0] geat_q, geat_d;
    logic                death_q, death_d;
    logic                clear_q, clear_d;

    logic [N_GHOSTS-1:0] hit;
    logic                pill_ev;
    logic                lethal;
    logic                last_pill;
    logic                do_clear;
    logic                do_pause;
    logic [3:0]          level_inc;

    genvar g;
    generate
        for (g = 0; g < N_GHOSTS; g++) begin : g_hit
            assign hit[g] = (ghost_x[g*X_W +: X_W] == pac_x)
                         && (ghost_y[g*Y_W +: Y_W] == pac_y);
        end
    endgenerate

    // Mutually exclusive GAME exits: death beats clear beats pause.
    assign pill_ev   = pill_eaten | power_eaten;
    assign lethal    = (|hit) & ~fright_q;
    assign last_pill = pill_ev & (pills_q == PILL_W'(1));
    assign do_clear  = last_pill & ~lethal;
    assign do_pause  = pause & ~lethal & ~last_pill;
    assign level_inc = (level_q == 4'd15) ? level_q : level_q + 4'd1;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q  <= S_INIT;
            lives_q  <= LIVES_LOAD;
            level_q  <= 4'd1;
            pills_q  <= PILL_LOAD;
            fright_q <= 1'b0;
            fcnt_q   <= '0;
            dcnt_q   <= '0;
            geat_q   <= '0;
            death_q  <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            level_q  <= level_d;
            pills_q  <= pills_d;
            fright_q <= fright_d;
            fcnt_q   <= fcnt_d;
            dcnt_q   <= dcnt_d;
            geat_q   <= geat_d;
            death_q  <= death_d;
            clear_q  <= clear_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        level_d  = level_q;
        pills_d  = pills_q;
        fright_d = fright_q;
        fcnt_d   = fcnt_q;
        dcnt_d   = dcnt_q;
        geat_d   = '0;
        death_d  = 1'b0;
        clear_d  = 1'b0;
        unique case (state_q)
            S_INIT: begin
                if (start) state_d = S_GAME;
            end
            S_GAME: begin
                if (pill_ev && pills_q != '0) pills_d = pills_q - 1'b1;
                if (power_eaten) begin
                    fright_d = 1'b1;
                    fcnt_d   = FRIGHT_LOAD;
                end else if (fright_q) begin
                    fcnt_d = fcnt_q - 1'b1;
                    if (fcnt_q == FW'(1)) fright_d = 1'b0;
                end
                if (fright_q) geat_d = hit;
                unique case (1'b1)
                    lethal: begin
                        death_d  = 1'b1;
                        fright_d = 1'b0;
                        fcnt_d   = '0;
                        if (lives_q != '0) lives_d = lives_q - 3'd1;
                        state_d  = (lives_q <= 3'd1) ? S_OVER : S_RESUME;
                    end
                    do_clear: begin
                        clear_d  = 1'b1;
                        level_d  = level_inc;
                        fright_d = 1'b0;
                        fcnt_d   = '0;
                        state_d  = S_CLEAR;
                    end
                    do_pause: state_d = S_PAUSE;
                    default: ;
                endcase
            end
            S_PAUSE: begin
                if (!pause) state_d = S_GAME;
            end
            S_RESUME: begin
                if (dcnt_q == DWELL_LAST) begin
                    dcnt_d = '0;
                    if (pills_q == '0) begin
                        clear_d = 1'b1;
                        level_d = level_inc;
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_GAME;
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_CLEAR: begin
                if (dcnt_q == DWELL_LAST) begin
                    dcnt_d  = '0;
                    pills_d = PILL_LOAD;
                    state_d = S_GAME;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_OVER: ;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        sprite_reset = 1'b0;
        map_wr_reset = 1'b0;
        disp_reset   = 1'b0;
        ghost_enable = 1'b0;
        unique case (state_q)
            S_INIT: begin
                sprite_reset = 1'b1;
                map_wr_reset = 1'b1;
                disp_reset   = 1'b1;
            end
            S_GAME:   ghost_enable = 1'b1;
            S_RESUME: sprite_reset = 1'b1;
            S_CLEAR: begin
                sprite_reset = 1'b1;
                map_wr_reset = 1'b1;
            end
            S_OVER:   map_wr_reset = 1'b1;
            default: ;
        endcase
    end

    assign state       = state_q;
    assign lives       = lives_q;
    assign level       = level_q;
    assign pills_left  = pills_q;
    assign frightened  = fright_q;
    assign ghost_eaten = geat_q;
    assign death       = death_q;
    assign level_clear = clear_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus random play,
// all checked every cycle against a behavioural game model.
module tb_game_flow_ctrl;

    localparam int NG = 3;
    localparam int XW = 6;
    localparam int YW = 5;
    localparam int NP = 4;
    localparam int RC = 8;
    localparam int FC = 16;

    logic          CLOCK_50 = 1'b0;
    logic          reset, start, pause, pill_eaten, power_eaten;
    logic [XW-1:0] pac_x;
    logic [YW-1:0] pac_y;
    logic [NG*XW-1:0] ghost_x;
    logic [NG*YW-1:0] ghost_y;
    logic [2:0]    state, lives;
    logic [3:0]    level;
    logic [8:0]    pills_left;
    logic          sprite_reset, map_wr_reset, disp_reset, ghost_enable;
    logic          frightened, death, level_clear;
    logic [NG-1:0] ghost_eaten;

    int checks = 0;
    int errors = 0;

    int   m_state, m_lives, m_level, m_pills, m_fleft, m_dwell;
    bit   m_fright, m_death, m_clear;
    logic [NG-1:0] m_ge;

    game_flow_ctrl #(
        .N_GHOSTS(NG), .X_W(XW), .Y_W(YW), .START_LIVES(3),
        .TOTAL_PILLS(NP), .PILL_W(9),
        .RESUME_CYCLES(RC), .FRIGHT_CYCLES(FC)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .pause(pause),
        .pac_x(pac_x), .pac_y(pac_y),
        .ghost_x(ghost_x), .ghost_y(ghost_y),
        .pill_eaten(pill_eaten), .power_eaten(power_eaten),
        .state(state), .lives(lives), .level(level),
        .pills_left(pills_left),
        .sprite_reset(sprite_reset), .map_wr_reset(map_wr_reset),
        .disp_reset(disp_reset), .ghost_enable(ghost_enable),
        .frightened(frightened), .ghost_eaten(ghost_eaten),
        .death(death), .level_clear(level_clear)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Control outputs each game phase must show: {sprite,map,disp,ghost_en}.
    function automatic logic [3:0] ctrl_exp(input int s);
        case (s)
            0: return 4'b1110;
            1: return 4'b0001;
            3: return 4'b1000;
            4: return 4'b1100;
            5: return 4'b0100;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_step();
        bit lethal, eat, last;
        logic [NG-1:0] hits;
        m_death = 0;
        m_clear = 0;
        m_ge    = '0;
        if (!reset) begin
            m_state = 0; m_lives = 3; m_level = 1; m_pills = NP;
            m_fright = 0; m_fleft = 0; m_dwell = 0;
            return;
        end
        for (int i = 0; i < NG; i++)
            hits[i] = (ghost_x[i*XW +: XW] == pac_x)
                   && (ghost_y[i*YW +: YW] == pac_y);
        case (m_state)
            0: if (start) m_state = 1;
            1: begin
                eat    = pill_eaten || power_eaten;
                last   = eat && (m_pills == 1);
                lethal = (hits != 0) && !m_fright;
                if (eat && m_pills > 0) m_pills--;
                if (lethal) begin
                    m_death = 1;
                    m_lives--;
                    m_fright = 0;
                    m_fleft = 0;
                    m_state = (m_lives == 0) ? 5 : 3;
                    m_dwell = RC;
                end else begin
                    if (m_fright) m_ge = hits;
                    if (power_eaten) begin
                        m_fright = 1;
                        m_fleft = FC;
                    end else if (m_fright) begin
                        m_fleft--;
                        if (m_fleft == 0) m_fright = 0;
                    end
                    if (last) begin
                        m_clear = 1;
                        m_level = (m_level < 15) ? m_level + 1 : 15;
                        m_fright = 0;
                        m_fleft = 0;
                        m_state = 4;
                        m_dwell = RC;
                    end else if (pause) begin
                        m_state = 2;
                    end
                end
            end
            2: if (!pause) m_state = 1;
            3: begin
                m_dwell--;
                if (m_dwell == 0) begin
                    if (m_pills == 0) begin
                        m_state = 4;
                        m_dwell = RC;
                        m_clear = 1;
                        m_level = (m_level < 15) ? m_level + 1 : 15;
                    end else begin
                        m_state = 1;
                    end
                end
            end
            4: begin
                m_dwell--;
                if (m_dwell == 0) begin
                    m_state = 1;
                    m_pills = NP;
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        chk("state", state, m_state);
        chk("lives", lives, m_lives);
        chk("level", level, m_level);
        chk("pills_left", pills_left, m_pills);
        chk("frightened", frightened, m_fright);
        chk("ghost_eaten", ghost_eaten, m_ge);
        chk("death", death, m_death);
        chk("level_clear", level_clear, m_clear);
        chk("controls",
            {sprite_reset, map_wr_reset, disp_reset, ghost_enable},
            ctrl_exp(m_state));
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        start = 0; pause = 0; pill_eaten = 0; power_eaten = 0;
        pac_x = 6'd10; pac_y = 5'd10;
        for (int i = 0; i < NG; i++) begin
            ghost_x[i*XW +: XW] = 6'(20 + i);
            ghost_y[i*YW +: YW] = 5'd3;
        end
    endtask

    task automatic hit_on(input int i);
        ghost_x[i*XW +: XW] = pac_x;
        ghost_y[i*YW +: YW] = pac_y;
    endtask

    task automatic restart();
        idle();
        reset = 0;
        step();
        reset = 1;
        start = 1;
        step();
        start = 0;
    endtask

    initial begin
        idle();
        reset = 0;
        step();
        chk("rst_state", state, 0);
        chk("rst_lives", lives, 3);
        chk("rst_level", level, 1);
        chk("rst_pills", pills_left, 4);
        chk("rst_sprite", sprite_reset, 1);
        reset = 1;
        start = 1;
        step();
        start = 0;
        chk("start_state", state, 1);
        chk("start_ghost_en", ghost_enable, 1);

        hit_on(0);
        hit_on(2);
        step();
        idle();
        chk("hit_death", death, 1);
        chk("hit_lives", lives, 2);
        chk("hit_resume", state, 3);
        for (int i = 1; i < RC; i++) begin
            step();
            chk("resume_dwell", state, 3);
            chk("resume_sprite", sprite_reset, 1);
            chk("resume_no_death", death, 0);
        end
        step();
        chk("resume_exit", state, 1);

        power_eaten = 1;
        step();
        power_eaten = 0;
        chk("fright_on", frightened, 1);
        hit_on(1);
        step();
        idle();
        chk("ghost_eaten", ghost_eaten, 3'b010);
        chk("eat_lives", lives, 2);
        step();
        chk("ghost_eaten_pulse", ghost_eaten, 0);
        pause = 1;
        repeat (5) step();
        pause = 0;
        chk("paused", state, 2);
        for (int k = 8; k <= 21; k++) begin
            step();
            chk("fright_span", frightened, (k < 21) ? 1 : 0);
        end

        restart();
        for (int j = 0; j < 4; j++) begin
            pill_eaten = 1;
            step();
            pill_eaten = 0;
            if (j < 3) step();
        end
        chk("clr_pills", pills_left, 0);
        chk("clr_pulse", level_clear, 1);
        chk("clr_level", level, 2);
        chk("clr_state", state, 4);
        for (int i = 1; i < RC; i++) begin
            step();
            chk("clr_dwell", state, 4);
            chk("clr_map", map_wr_reset, 1);
        end
        step();
        chk("clr_exit", state, 1);
        chk("clr_reload", pills_left, 4);

        restart();
        for (int j = 0; j < 3; j++) begin
            pill_eaten = 1;
            step();
            pill_eaten = 0;
        end
        pill_eaten = 1;
        hit_on(0);
        step();
        idle();
        chk("both_death", death, 1);
        chk("both_lives", lives, 2);
        chk("both_pills", pills_left, 0);
        chk("both_state", state, 3);
        repeat (RC) step();
        chk("both_clear", state, 4);
        chk("both_level", level, 2);
        repeat (RC) step();
        chk("both_game", state, 1);
        chk("both_reload", pills_left, 4);

        restart();
        for (int h = 0; h < 3; h++) begin
            hit_on(0);
            step();
            idle();
            if (h < 2) repeat (RC) step();
        end
        chk("over_state", state, 5);
        chk("over_lives", lives, 0);
        for (int i = 0; i < 6; i++) begin
            start = ~start;
            step();
            chk("over_hold", state, 5);
        end
        chk("over_map", map_wr_reset, 1);

        restart();
        hit_on(1);
        step();
        idle();
        repeat (3) step();
        reset = 0;
        step();
        reset = 1;
        chk("abort_state", state, 0);
        chk("abort_lives", lives, 3);

        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 249) != 0);
            start = ($urandom_range(0, 1) != 0);
            if (pause) pause = ($urandom_range(0, 3) != 0);
            else pause = ($urandom_range(0, 29) == 0);
            pill_eaten  = ($urandom_range(0, 4) == 0);
            power_eaten = ($urandom_range(0, 24) == 0);
            pac_x = 6'($urandom_range(0, 63));
            pac_y = 5'($urandom_range(0, 31));
            for (int i = 0; i < NG; i++) begin
                if ($urandom_range(0, 59) == 0) begin
                    hit_on(i);
                end else begin
                    ghost_x[i*XW +: XW] = 6'($urandom_range(0, 63));
                    ghost_y[i*YW +: YW] = 5'($urandom_range(0, 31));
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameters (name, default, meaning): N_GHOSTS, 2, ghost count (1-8); X_W, 6, tile x width; Y_W, 5, tile y width; START_LIVES, 3, lives loaded at reset (1-7); TOTAL_PILLS, 300, pills per level; PILL_W, 9, pills_left width; RESUME_CYCLES, 250000000, RESUME/CLEAR dwell in clocks; FRIGHT_CYCLES, 350000000, frightened duration in clocks.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset, with these ports (name, direction, width, meaning):
- CLOCK_50  in  1  sole clock, all state on rising edge.
- reset  in  1  synchronous active-low reset.
- start  in  1  level, leave INIT.
- pause  in  1  level, pause request.
- pac_x / pac_y  in  X_W / Y_W  pacman tile.
- ghost_x / ghost_y  in  N_GHOSTS*X_W / N_GHOSTS*Y_W  ghost i at slice [i*W +: W].
- pill_eaten  in  1  one-cycle pulse, normal pill consumed.
- power_eaten  in  1  one-cycle pulse, power pill consumed.
- state  out  3  INIT=0, GAME=1, PAUSE=2, RESUME=3, CLEAR=4, OVER=5.
- lives  out  3  remaining lives.
- level  out  4  current level.
- pills_left  out  PILL_W  pills remaining.
- sprite_reset, map_wr_reset, disp_reset, ghost_enable  out  1 each  Moore controls.
- frightened  out  1  ghosts edible.
- ghost_eaten  out  N_GHOSTS  one-cycle pulse per ghost eaten.
- death, level_clear  out  1 each  one-cycle event pulses.

Function
REQ-003 Controls SHALL be decoded from the state register only: INIT: sprite_reset=map_wr_reset=disp_reset=1, ghost_enable=0; GAME: all three resets 0, ghost_enable=1; PAUSE: all 0; RESUME: sprite_reset=1, others 0; CLEAR: sprite_reset=map_wr_reset=1, disp_reset=0; OVER: map_wr_reset=1, others 0; ghost_enable=0 outside GAME.
REQ-004 INIT->GAME when start=1.
REQ-005 Collision hit[i] SHALL be (ghost i x,y == pac_x,pac_y), evaluated only in GAME.
REQ-006 In GAME with any hit and frightened=0: death pulses next cycle; lives decrements exactly once regardless of how many ghosts hit; if lives was 1, lives=0 and next state OVER, else next state RESUME.
REQ-007 In GAME with frightened=1: ghost_eaten[i] pulses next cycle for every hit[i]; no life lost; state stays GAME.
REQ-008 RESUME and CLEAR SHALL dwell exactly RESUME_CYCLES clocks (counter cleared on entry), then go to GAME.
REQ-009 pills_left SHALL decrement by 1 for each GAME cycle with pill_eaten or power_eaten (both in same cycle = 1), saturating at 0; events outside GAME ignored.
REQ-010 When pills_left goes 1->0 in GAME with no death that cycle: level_clear pulses next cycle, level increments (saturate at 15), next state CLEAR; on CLEAR->GAME pills_left reloads TOTAL_PILLS.
REQ-011 Priority in one GAME cycle: death > last-pill clear > pause; a lethal hit in the same cycle as the last pill gives death, pills_left still becomes 0, CLEAR is entered from RESUME exit instead of GAME (RESUME->CLEAR when pills_left=0).
REQ-012 power_eaten in GAME SHALL set frightened=1 and load fright counter with FRIGHT_CYCLES; a repeat reloads it; frightened clears when counter expires, on death, or on entering CLEAR.
REQ-013 GAME->PAUSE when pause=1 (subject to REQ-011); PAUSE->GAME when pause=0; fright counter and all counters freeze in PAUSE.
REQ-014 OVER SHALL be terminal until reset; start ignored.
REQ-015 Counters SHALL be sized $clog2 of their limits; no wrap beyond limits.

Reset
REQ-016 With reset=0 on a clock edge: state=INIT, lives=START_LIVES, level=1, pills_left=TOTAL_PILLS, frightened=0, all pulses 0, all counters 0; reset mid-RESUME/CLEAR/PAUSE aborts immediately to these values.

Verification (bench params: N_GHOSTS=3, TOTAL_PILLS=4, RESUME_CYCLES=8, FRIGHT_CYCLES=16)
REQ-017 Reset, start=1 -> state 0 then 1; lives=3, level=1, pills_left=4, ghost_enable=1.
REQ-018 Ghosts 0 and 2 both on pacman, not frightened -> one death pulse, lives 3->2, RESUME for 8 clocks with sprite_reset=1, back to GAME.
REQ-019 Three lethal hits -> lives 0, state OVER; start toggling keeps OVER.
REQ-020 power_eaten, then ghost 1 on pacman -> ghost_eaten=3'b010 one cycle, lives unchanged; frightened falls 16 clocks after last power_eaten; pause 5 clocks in between extends it by 5.
REQ-021 Four pill pulses -> pills_left 0, level_clear pulse, level=2, CLEAR 8 clocks, pills_left reloaded to 4.
REQ-022 Last pill and lethal hit same cycle -> death, lives-1, RESUME then CLEAR, level=2.
